// File: rtl/stack_ctrl_pkg.sv
// Shared types and defaults for the two-requester 1-bit stack controller.
//   state_e : controller FSM states (IDLE -> ISSUE -> SETTLE -> IDLE)
//   op_e    : operation latched at grant time
//   DEPTH_DEF / CNT_W_DEF : default stack depth and occupancy counter width
package stack_ctrl_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

endpackage

// File: rtl/stack_arbiter_if.sv
// Bundle of every non-clock/reset signal of stack_arbiter.
//   slave  : view of the controller (consumes requests/stk_top/err_clr,
//            drives grants, responses, stack strobes and status)
//   master : view of the surrounding logic (requesters plus stack instance)
// Requester ports: reqN_push/pop/data in, reqN_gnt/rsp_valid/rsp_data out.
// Stack ports: stk_push/stk_pop/stk_data out, stk_top in.
// Status: count, full, empty, err_ovf, err_unf out; err_clr in.
interface stack_arbiter_if #(
  parameter int CNT_W = 4
);
  logic             req0_push, req0_pop, req0_data;
  logic             req0_gnt, req0_rsp_valid, req0_rsp_data;
  logic             req1_push, req1_pop, req1_data;
  logic             req1_gnt, req1_rsp_valid, req1_rsp_data;
  logic             stk_push, stk_pop, stk_data, stk_top;
  logic [CNT_W-1:0] count;
  logic             full, empty, err_ovf, err_unf, err_clr;

  modport slave (
    input  req0_push, req0_pop, req0_data, req1_push, req1_pop, req1_data,
    input  stk_top, err_clr,
    output req0_gnt, req0_rsp_valid, req0_rsp_data,
    output req1_gnt, req1_rsp_valid, req1_rsp_data,
    output stk_push, stk_pop, stk_data, count, full, empty, err_ovf, err_unf
  );

  modport master (
    output req0_push, req0_pop, req0_data, req1_push, req1_pop, req1_data,
    output stk_top, err_clr,
    input  req0_gnt, req0_rsp_valid, req0_rsp_data,
    input  req1_gnt, req1_rsp_valid, req1_rsp_data,
    input  stk_push, stk_pop, stk_data, count, full, empty, err_ovf, err_unf
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   CLK, RST : clock, synchronous active-high reset
//   req[1:0] : eligible requests
//   enable   : arbitration allowed this cycle (grants forced low otherwise)
//   gnt[1:0] : one-hot combinational grant
// ptr_q holds the last winner; on a conflict the other requester wins.
// Reset value 1 makes requester 0 win the first conflict.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = 1'b0;
    else if (gnt[1]) ptr_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/stack_arbiter.sv
// Shares one 1-bit LIFO between two requesters.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : stack_arbiter_if.slave (requests, grants, pop responses,
//              stack strobes, occupancy and sticky error flags)
// Each grant runs IDLE -> ISSUE -> SETTLE. Occupancy is counted at grant
// time so full/empty come straight from a register; pop data is sampled
// from stk_top at the grant edge, before the pop strobe is issued.
module stack_arbiter
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic           CLK,
  input logic           RST,
  stack_arbiter_if.slave bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  op_e              op_q;
  logic             data_q, owner_q;
  logic             rsp0_q, rsp1_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full, empty, arb_en, win, issue, any_gnt, win_push;
  logic [1:0]       push_v, pop_v, elig, gnt;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Push takes priority when a requester raises both
  assign push_v   = {bus.req1_push, bus.req0_push};
  assign pop_v    = {bus.req1_pop & ~bus.req1_push, bus.req0_pop & ~bus.req0_push};
  assign elig     = (push_v & {2{~full}}) | (pop_v & {2{~empty}});
  assign arb_en   = (state_q == IDLE) && !RST;
  assign any_gnt  = |gnt;
  assign win      = gnt[1];
  assign win_push = push_v[win];

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .req    (elig),
    .enable (arb_en),
    .gnt    (gnt)
  );

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_gnt) state_d = ISSUE;
      ISSUE:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs (reset suppresses any strobe/response for its edge)
  always_comb begin
    issue              = (state_q == ISSUE) && !RST;
    bus.stk_push       = issue && (op_q == OP_PUSH);
    bus.stk_pop        = issue && (op_q == OP_POP);
    bus.stk_data       = issue && (op_q == OP_PUSH) && data_q;
    bus.req0_rsp_valid = issue && (op_q == OP_POP) && !owner_q;
    bus.req1_rsp_valid = issue && (op_q == OP_POP) && owner_q;
    bus.req0_gnt       = gnt[0];
    bus.req1_gnt       = gnt[1];
  end

  always_comb begin
    count_d = count_q;
    if (any_gnt) count_d = win_push ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
  end

  // Set has priority over clear
  always_comb begin
    ovf_d = (ovf_q && !bus.err_clr) || ((state_q == IDLE) && full  && |push_v);
    unf_d = (unf_q && !bus.err_clr) || ((state_q == IDLE) && empty && |pop_v);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (any_gnt && !win_push) begin
        if (win) rsp1_q <= bus.stk_top;
        else     rsp0_q <= bus.stk_top;
      end
    end
  end

  // Operation context, only meaningful while ISSUE is active
  always_ff @(posedge CLK) begin
    if (any_gnt) begin
      op_q    <= win_push ? OP_PUSH : OP_POP;
      data_q  <= win ? bus.req1_data : bus.req0_data;
      owner_q <= win;
    end
  end

  assign bus.req0_rsp_data = rsp0_q;
  assign bus.req1_rsp_data = rsp1_q;
  assign bus.count         = count_q;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.err_ovf       = ovf_q;
  assign bus.err_unf       = unf_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a cycle table of {inputs, expected outputs}
// followed by hand sequences for round-robin alternation and the
// full/overflow corner. A small behavioural LIFO drives stk_top.
module tb_stack_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_arbiter_if #(.CNT_W(4)) bus ();
  stack_arbiter #(.DEPTH(8), .CNT_W(4)) dut (.CLK(clk), .RST(rst), .bus(bus));

  // Behavioural stack
  logic mem [8];
  int   sp;
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (bus.stk_push && sp < 8) begin
      mem[sp] <= bus.stk_data;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) sp <= sp - 1;
  end
  always_comb bus.stk_top = (sp > 0) ? mem[sp-1] : 1'b0;

  // in  = {rst, p0, q0, d0, p1, q1, d1, clr}
  // exp = {g0, g1, stk_push, stk_pop, stk_data, rv0, rv1, rd0, rd1,
  //        count[3:0], full, empty, err_ovf, err_unf}
  typedef struct {
    logic [7:0]  in;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  task automatic add(input logic [7:0] i, input logic [8:0] f,
                     input logic [3:0] c, input logic [3:0] s);
    vec_t v;
    v.in  = i;
    v.exp = {f, c, s};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive point: 1 time unit after the falling edge
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] i);
    {rst, bus.req0_push, bus.req0_pop, bus.req0_data,
     bus.req1_push, bus.req1_pop, bus.req1_data, bus.err_clr} = i;
  endtask

  task automatic do_reset();
    cyc(); set_in(8'b1_000_000_0);
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic do_push0(input logic d);
    int w;
    cyc();
    bus.req0_push = 1'b1;
    bus.req0_data = d;
    #1;
    w = 0;
    while (!bus.req0_gnt && w < 8) begin
      cyc(); #1; w++;
    end
    chk("push0_gnt", 32'(bus.req0_gnt), 32'd1);
    cyc(); bus.req0_push = 1'b0;
    cyc();
  endtask

  initial begin
    logic [16:0] act;
    int gcyc[$];
    int gwho[$];
    int w;
    logic seen;

    set_in(8'b1_000_000_0);

    add(8'b1_000_000_0, 9'b00_000_00_00, 4'd0, 4'b0100);  // reset state
    add(8'b1_000_000_0, 9'b00_000_00_00, 4'd0, 4'b0100);
    add(8'b0_101_000_0, 9'b10_000_00_00, 4'd0, 4'b0100);  // push 1 granted
    add(8'b0_000_000_0, 9'b00_101_00_00, 4'd1, 4'b0000);  // ISSUE
    add(8'b0_000_000_0, 9'b00_000_00_00, 4'd1, 4'b0000);  // SETTLE
    add(8'b0_100_000_0, 9'b10_000_00_00, 4'd1, 4'b0000);  // push 0
    add(8'b0_000_000_0, 9'b00_100_00_00, 4'd2, 4'b0000);
    add(8'b0_000_000_0, 9'b00_000_00_00, 4'd2, 4'b0000);
    add(8'b0_101_000_0, 9'b10_000_00_00, 4'd2, 4'b0000);  // push 1
    add(8'b0_000_000_0, 9'b00_101_00_00, 4'd3, 4'b0000);
    add(8'b0_000_000_0, 9'b00_000_00_00, 4'd3, 4'b0000);
    add(8'b0_000_010_0, 9'b01_000_00_00, 4'd3, 4'b0000);  // req1 pop -> 1
    add(8'b0_000_000_0, 9'b00_010_01_01, 4'd2, 4'b0000);
    add(8'b0_000_000_0, 9'b00_000_00_01, 4'd2, 4'b0000);
    add(8'b0_000_010_0, 9'b01_000_00_01, 4'd2, 4'b0000);  // pop -> 0
    add(8'b0_000_000_0, 9'b00_010_01_00, 4'd1, 4'b0000);
    add(8'b0_000_000_0, 9'b00_000_00_00, 4'd1, 4'b0000);
    add(8'b0_000_010_0, 9'b01_000_00_00, 4'd1, 4'b0000);  // pop -> 1
    add(8'b0_000_000_0, 9'b00_010_01_01, 4'd0, 4'b0100);
    add(8'b0_000_000_0, 9'b00_000_00_01, 4'd0, 4'b0100);
    add(8'b0_000_010_0, 9'b00_000_00_01, 4'd0, 4'b0100);  // pop while empty
    add(8'b0_000_010_0, 9'b00_000_00_01, 4'd0, 4'b0101);
    add(8'b0_000_010_1, 9'b00_000_00_01, 4'd0, 4'b0101);  // set beats clear
    add(8'b0_000_000_1, 9'b00_000_00_01, 4'd0, 4'b0101);  // clear
    add(8'b0_000_000_0, 9'b00_000_00_01, 4'd0, 4'b0100);
    add(8'b0_000_101_0, 9'b01_000_00_01, 4'd0, 4'b0100);  // req1 push
    add(8'b1_000_000_0, 9'b00_000_00_01, 4'd1, 4'b0000);  // reset in ISSUE
    add(8'b0_000_000_0, 9'b00_000_00_00, 4'd0, 4'b0100);
    add(8'b0_111_000_0, 9'b10_000_00_00, 4'd0, 4'b0100);  // push+pop = push
    add(8'b0_000_000_0, 9'b00_101_00_00, 4'd1, 4'b0000);
    add(8'b0_000_000_0, 9'b00_000_00_00, 4'd1, 4'b0000);
    add(8'b0_010_000_0, 9'b10_000_00_00, 4'd1, 4'b0000);  // req0 pop -> 1
    add(8'b0_000_000_0, 9'b00_010_10_10, 4'd0, 4'b0100);
    add(8'b0_000_000_0, 9'b00_000_00_10, 4'd0, 4'b0100);

    for (int n = 0; n < tbl.size(); n++) begin
      cyc();
      set_in(tbl[n].in);
      #1;
      act = {bus.req0_gnt, bus.req1_gnt, bus.stk_push, bus.stk_pop, bus.stk_data,
             bus.req0_rsp_valid, bus.req1_rsp_valid, bus.req0_rsp_data,
             bus.req1_rsp_data, bus.count, bus.full, bus.empty,
             bus.err_ovf, bus.err_unf};
      chk($sformatf("vec[%0d]", n), 32'(act), 32'(tbl[n].exp));
    end

    // Both requesters pushing continuously: alternate 0,1,0,1 every 3 cycles
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 0) begin
        bus.req0_push = 1'b1; bus.req0_data = 1'b1;
        bus.req1_push = 1'b1; bus.req1_data = 1'b0;
      end
      #1;
      if (bus.req0_gnt && bus.req1_gnt) chk("double_gnt", 32'd1, 32'd0);
      if (bus.req0_gnt || bus.req1_gnt) begin
        gcyc.push_back(i);
        gwho.push_back(bus.req1_gnt ? 1 : 0);
      end
    end
    chk("alt_count", 32'(gcyc.size()), 32'd4);
    for (int k = 0; k < gcyc.size() && k < 4; k++) begin
      chk($sformatf("alt_who[%0d]", k), 32'(gwho[k]), 32'(k % 2));
      chk($sformatf("alt_cyc[%0d]", k), 32'(gcyc[k]), 32'(3 * k));
    end

    // Fill to DEPTH, then overflow blocking and recovery through a pop
    do_reset();
    for (int k = 0; k < 8; k++) do_push0(k[0]);
    chk("fill_count", 32'(bus.count), 32'd8);
    chk("fill_full", 32'(bus.full), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.req0_push = 1'b1;
      #1;
      seen |= bus.req0_gnt;
    end
    chk("full_no_gnt0", 32'(seen), 32'd0);
    chk("err_ovf_set", 32'(bus.err_ovf), 32'd1);
    cyc(); bus.req1_pop = 1'b1; #1;
    chk("full_gnt1", 32'(bus.req1_gnt), 32'd1);
    chk("full_gnt0_blk", 32'(bus.req0_gnt), 32'd0);
    cyc(); bus.req1_pop = 1'b0; #1;
    chk("pop_count", 32'(bus.count), 32'd7);
    chk("pop_strobe", 32'(bus.stk_pop), 32'd1);
    w = 0;
    do begin
      cyc(); #1; w++;
    end while (!bus.req0_gnt && w < 6);
    chk("regrant_delay", 32'(w), 32'd2);
    cyc(); bus.req0_push = 1'b0; #1;
    chk("refill_count", 32'(bus.count), 32'd8);
    cyc();
    cyc(); bus.err_clr = 1'b1; #1;
    chk("ovf_before_clr", 32'(bus.err_ovf), 32'd1);
    cyc(); bus.err_clr = 1'b0; #1;
    chk("ovf_cleared", 32'(bus.err_ovf), 32'd0);
    chk("still_full", 32'(bus.full), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Controller that shares one 1-bit LIFO stack (DEPTH entries, strobe push/pop, top-of-stack output) between two requesters. It tracks occupancy and blocks illegal operations, so the stack never sees a push when full or a pop when empty. It arbitrates round-robin, sequences each operation through a 3-state FSM, and returns popped bits to the owning requester. It sits between the requester logic and the stack instance.

Parameters:
DEPTH, 8, stack entries; must match the attached stack
CNT_W, 4, occupancy counter width; clog2(DEPTH+1)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous, active-high reset
req0_push  in  1  requester 0 push request; held until req0_gnt
req0_pop  in  1  requester 0 pop request; held until req0_gnt
req0_data  in  1  requester 0 push bit; stable while req0_push is high
req0_gnt  out  1  requester 0 grant, 1-cycle pulse
req0_rsp_valid  out  1  requester 0 pop data valid, 1-cycle pulse
req0_rsp_data  out  1  requester 0 popped bit
req1_push, req1_pop, req1_data, req1_gnt, req1_rsp_valid, req1_rsp_data: same as requester 0
stk_push  out  1  push strobe to stack
stk_pop  out  1  pop strobe to stack
stk_data  out  1  bit to push
stk_top  in  1  current top-of-stack bit from stack
count  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
err_ovf  out  1  sticky: a push was presented while full
err_unf  out  1  sticky: a pop was presented while empty
err_clr  in  1  clears both error flags

Behaviour:
- Reset values: FSM=IDLE, count=0, empty=1, full=0, all strobes/grants/rsp_valid=0, rsp_data=0, err flags=0, rr pointer=1 (requester 0 wins first conflict). Stack contents are invalid after reset; count is authoritative.
- Requester op: push if pushN=1, else pop if popN=1. Push and pop together means push; pop is ignored.
- Eligibility: push is eligible iff !full; pop is eligible iff !empty.
- FSM IDLE: if any eligible request exists, grant exactly one.
  - Conflict: grant the requester not granted last; update the pointer to the winner.
  - gntN pulses combinationally in this cycle.
  - On this edge: count±1, latch op, data and owner; for a pop, capture stk_top into rsp_data.
  - Transition to ISSUE. No eligible request: stay in IDLE.
- FSM ISSUE (1 cycle): stk_push or stk_pop=1 and stk_data=latched bit. For a pop, owner's rsp_valid=1. Next state SETTLE.
- FSM SETTLE (1 cycle): strobes 0. Lets stk_top reflect the update. Next state IDLE.
- Timing: grant-to-grant is 3 cycles minimum. Pop data reaches the requester 1 cycle after grant.
- Errors: in IDLE, err_ovf sets if any push is presented while full; err_unf sets if any pop is presented while empty. Blocked requests are not granted and stay pending.
- Error clear: err_clr clears both flags. If err_clr and a set condition occur in the same cycle, set wins.
- Boundaries:
  - Count saturates by construction (never exceeds DEPTH, never below 0).
  - One requester eligible and the other blocked: the eligible one is granted and the pointer updates.
- RST in any state: returns to IDLE on the next edge. Any strobe for that edge is suppressed and an in-flight rsp_valid is dropped.
- full and empty are decoded from registered count (no combinational path from requests).

Decomposition:
- Package stack_ctrl_pkg: FSM state enum {IDLE, ISSUE, SETTLE}, op enum {OP_PUSH, OP_POP}, DEPTH default.
- Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], enable, gnt[1:0], pointer register, CLK/RST).

Test Plan:
- Reset then req0_push data=1 -> gnt0 at cycle 0, stk_push=1 with stk_data=1 at cycle 1, count=1, empty=0.
- Push 1,0,1 from req0, then req1_pop ×3 -> req1_rsp_data sequence 1,0,1, each rsp_valid 1 cycle after its gnt1; count returns to 0, empty=1.
- req0_push and req1_push held together from reset -> grants alternate 0,1,0,1, 3 cycles apart.
- Push 8 times, then req0_push held -> full=1, no gnt0, err_ovf=1. req1_pop -> granted, count=7, then req0 is granted. Assert err_clr -> err_ovf=0.
- After reset, req1_pop only -> never granted, err_unf=1, stk_pop never asserts.
- RST asserted during ISSUE of a push -> next cycle IDLE, count=0, stk_push=0, no rsp_valid.
